mult_res_acc: RTL and testbench
===============================

Name: mult_res_acc

Overview:
- Downstream consumer of the sequential multiplier `mult_low`.
- Watches the multiplier's `res_rdy`/`res` outputs and captures each new product exactly once.
- Accumulates K products into a saturating sum, then presents the sum on a valid/ack handshake.
- Used to build dot-product and sum-of-products results from back-to-back multiplications.

Parameters:
- N, 8: width of multiplier operand 1, matching the upstream multiplier.
- M, 4: width of multiplier operand 2. Product width is M+N.
- K, 4: number of products per frame. Legal range 1..255.
- ACC_W, 16: accumulator width. Must be >= M+N.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- res_rdy  in  1  upstream result-ready level; may be held high for several cycles.
- res  in  M+N  upstream product; valid while res_rdy=1.
- acc_ack  in  1  consumer accepts the frame sum.
- acc_vld  out  1  frame sum valid.
- acc_sum  out  ACC_W  saturated sum of K products.
- acc_sat  out  1  sticky: saturation occurred in this frame.
- acc_cnt  out  8  number of products captured in the current frame.
- in_drop  out  1  one-cycle pulse: a product arrived while a sum was pending and was discarded.

Behaviour:
- Reset (async, rstn=0):
  - acc_vld=0, acc_sum=0, acc_sat=0, acc_cnt=0, in_drop=0, state=IDLE.
  - Internal res_rdy_r=1, so a res_rdy already high at reset release is NOT captured.
- Edge detect:
  - cap = res_rdy & ~res_rdy_r, evaluated each rising clk.
  - res_rdy_r <= res_rdy every cycle.
  - A level held high gives exactly one capture; capture requires a 0 then 1 transition.
- States:
  - IDLE (acc_cnt=0), ACC (0<acc_cnt<K), HOLD (acc_vld=1).
- IDLE/ACC on cap, same clock edge (zero-cycle capture latency):
  - t = acc_sum + zero-extended res.
  - If t > 2^ACC_W-1: acc_sum <= 2^ACC_W-1 and acc_sat <= 1. Otherwise acc_sum <= t.
  - acc_cnt <= acc_cnt+1.
  - If the new acc_cnt == K: go to HOLD and acc_vld <= 1 on the same edge. Otherwise go to/stay in ACC.
- Saturation is sticky within a frame: once saturated, further captures keep acc_sum at its maximum.
- HOLD:
  - acc_sum, acc_sat and acc_cnt=K stay stable until acc_ack=1.
  - cap while acc_ack=0: product discarded; in_drop=1 for exactly that one cycle; sum unchanged.
- acc_ack=1 in HOLD:
  - Next edge: acc_vld=0, acc_sum=0, acc_sat=0, acc_cnt=0, state=IDLE.
  - If cap in the same cycle: the product opens the new frame instead (acc_sum <= res, acc_cnt <= 1, sat per rule, state=ACC, no in_drop).
  - K=1 with simultaneous ack+cap: go straight back to HOLD with the new sum.
- acc_ack outside HOLD is ignored.
- Reset mid-frame: partial sum discarded; all outputs return to reset values immediately (asynchronously).
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Nominal frame (N=8, M=4, K=4, ACC_W=16), driving `mult_low` with (25,5), (16,10), (10,4), (15,7):
  - Products 125, 160, 40, 105 are each captured once.
  - acc_cnt steps 1→2→3→4; acc_vld rises on the 4th capture edge.
  - acc_sum=430, acc_sat=0. Pulse acc_ack → acc_vld=0, acc_sum=0 next edge.
- Held level: res=100, res_rdy held high 6 cycles then low, repeated 4 times → acc_sum=400, exactly 4 captures.
  - res_rdy high at reset release → no capture (acc_cnt stays 0) until after a low cycle.
- Saturation (ACC_W=12, K=4): products 1935, 1935, 1935, 10:
  - acc_sum=4095 after the 3rd capture and remains 4095.
  - acc_sat=1 at acc_vld. acc_sat clears after ack.
- Drop and simultaneous events:
  - In HOLD with sum 430, a new product 50 with acc_ack=0 → in_drop one cycle, acc_sum still 430.
  - Then a new product 50 with acc_ack=1 in the same cycle → acc_vld=0, acc_sum=50, acc_cnt=1, in_drop=0.
- Reset mid-frame: after 2 captures (sum 285), pulse rstn low between clock edges:
  - Outputs clear immediately, with no clock edge needed.
  - Next 4 products 125, 160, 40, 105 → acc_sum=430 (no residue).
- K=1: each product with no ack → acc_vld, acc_sum=product.
  - Ack and cap together with products 7 then 9 → acc_sum goes 7 then 9, acc_vld stays high continuously.

Source files
------------

// File: rtl/mult_res_acc.sv
// Frame accumulator behind the sequential multiplier: captures each new product once on the
// rising edge of res_rdy, sums K of them with saturation, and offers the sum on a valid/ack handshake.
module mult_res_acc #(
   parameter int N     = 8,
   parameter int M     = 4,
   parameter int K     = 4,
   parameter int ACC_W = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               res_rdy,
   input  logic [M+N-1:0]     res,
   input  logic               acc_ack,
   output logic               acc_vld,
   output logic [ACC_W-1:0]   acc_sum,
   output logic               acc_sat,
   output logic [7:0]         acc_cnt,
   output logic               in_drop
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] SUM_MAX = '1;
   localparam logic [7:0]       K_CNT   = 8'(K);

   state_t             state;
   logic               res_rdy_r;
   logic               cap;
   logic               take;
   logic               clear;
   logic [ACC_W-1:0]   base_sum;
   logic               base_sat;
   logic [7:0]         base_cnt;
   logic [ACC_W:0]     sum_ext;
   logic [ACC_W-1:0]   new_sum;
   logic               new_sat;
   logic [7:0]         new_cnt;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cap      = res_rdy & ~res_rdy_r;
      take     = cap & ((state != HOLD) | acc_ack);
      clear    = (state == HOLD) & acc_ack & ~cap;
      base_sum = acc_sum;
      base_sat = acc_sat;
      base_cnt = acc_cnt;
      // An acknowledged sum is retired this edge, so a coincident product starts from zero.
      if (state == HOLD) begin
         base_sum = '0;
         base_sat = 1'b0;
         base_cnt = 8'd0;
      end
      sum_ext = {1'b0, base_sum} + (ACC_W+1)'(res);
      new_sum = sum_ext[ACC_W-1:0];
      new_sat = base_sat;
      if (sum_ext[ACC_W]) begin
         new_sum = SUM_MAX;
         new_sat = 1'b1;
      end
      new_cnt = base_cnt + 8'd1;
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         // NOTE: res_rdy_r resets high so a level already present at reset release is not a new product.
         res_rdy_r <= 1'b1;
         acc_vld   <= 1'b0;
         acc_sum   <= '0;
         acc_sat   <= 1'b0;
         acc_cnt   <= 8'd0;
         in_drop   <= 1'b0;
      end else begin
         res_rdy_r <= res_rdy;
         in_drop   <= 1'b0;
         if (take) begin
            acc_sum <= new_sum;
            acc_sat <= new_sat;
            acc_cnt <= new_cnt;
            if (new_cnt == K_CNT) begin
               state   <= HOLD;
               acc_vld <= 1'b1;
            end else begin
               state   <= ACC;
               acc_vld <= 1'b0;
            end
         end else if (clear) begin
            state   <= IDLE;
            acc_vld <= 1'b0;
            acc_sum <= '0;
            acc_sat <= 1'b0;
            acc_cnt <= 8'd0;
         end else if ((state == HOLD) && cap) begin
            in_drop <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mult_res_acc.sv
// Directed bench for mult_res_acc: three instances cover the nominal frame, saturation
// at a 12-bit accumulator, and single-product frames.
module tb_mult_res_acc;

   logic        clk = 1'b0;
   logic        res_rdy;
   logic [11:0] res;

   logic        rstn_m, ack_m, vld_m, sat_m, drop_m;
   logic [15:0] sum_m;
   logic [7:0]  cnt_m;

   logic        rstn_s, ack_s, vld_s, sat_s, drop_s;
   logic [11:0] sum_s;
   logic [7:0]  cnt_s;

   logic        rstn_k, ack_k, vld_k, sat_k, drop_k;
   logic [15:0] sum_k;
   logic [7:0]  cnt_k;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mult_res_acc #(.N(8), .M(4), .K(4), .ACC_W(16)) u_main (
      .clk(clk), .rstn(rstn_m), .res_rdy(res_rdy), .res(res), .acc_ack(ack_m),
      .acc_vld(vld_m), .acc_sum(sum_m), .acc_sat(sat_m), .acc_cnt(cnt_m), .in_drop(drop_m));

   mult_res_acc #(.N(8), .M(4), .K(4), .ACC_W(12)) u_sat (
      .clk(clk), .rstn(rstn_s), .res_rdy(res_rdy), .res(res), .acc_ack(ack_s),
      .acc_vld(vld_s), .acc_sum(sum_s), .acc_sat(sat_s), .acc_cnt(cnt_s), .in_drop(drop_s));

   mult_res_acc #(.N(8), .M(4), .K(1), .ACC_W(16)) u_k1 (
      .clk(clk), .rstn(rstn_k), .res_rdy(res_rdy), .res(res), .acc_ack(ack_k),
      .acc_vld(vld_k), .acc_sum(sum_k), .acc_sat(sat_k), .acc_cnt(cnt_k), .in_drop(drop_k));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One product: res_rdy high for one cycle, then low for one cycle.
   task automatic deliver(input logic [11:0] value);
      res     = value;
      res_rdy = 1'b1;
      tick();
      res_rdy = 1'b0;
      tick();
   endtask

   initial begin
      res_rdy = 1'b0;
      res     = '0;
      rstn_m  = 1'b0; ack_m = 1'b0;
      rstn_s  = 1'b0; ack_s = 1'b0;
      rstn_k  = 1'b0; ack_k = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_vld", vld_m, 0);
      check("rst_sum", sum_m, 0);
      check("rst_sat", sat_m, 0);
      check("rst_cnt", cnt_m, 0);
      check("rst_drop", drop_m, 0);
      rstn_m = 1'b1;
      tick();

      // Nominal frame: 125 + 160 + 40 + 105 = 430
      deliver(12'd125);
      check("nom_cnt1", cnt_m, 1);
      check("nom_sum1", sum_m, 125);
      deliver(12'd160);
      check("nom_cnt2", cnt_m, 2);
      check("nom_sum2", sum_m, 285);
      deliver(12'd40);
      check("nom_cnt3", cnt_m, 3);
      check("nom_sum3", sum_m, 325);
      check("nom_vld3", vld_m, 0);
      res = 12'd105; res_rdy = 1'b1;
      tick();
      check("nom_vld4", vld_m, 1);
      check("nom_cnt4", cnt_m, 4);
      check("nom_sum4", sum_m, 430);
      check("nom_sat4", sat_m, 0);
      res_rdy = 1'b0;
      tick(); tick();
      check("hold_vld", vld_m, 1);
      check("hold_sum", sum_m, 430);
      ack_m = 1'b1;
      tick();
      ack_m = 1'b0;
      check("ack_vld", vld_m, 0);
      check("ack_sum", sum_m, 0);
      check("ack_cnt", cnt_m, 0);

      // Ack outside HOLD is ignored; build another 430 frame
      ack_m = 1'b1;
      deliver(12'd125);
      ack_m = 1'b0;
      check("ign_ack_cnt", cnt_m, 1);
      check("ign_ack_sum", sum_m, 125);
      deliver(12'd160);
      deliver(12'd40);
      deliver(12'd105);
      check("f2_vld", vld_m, 1);
      check("f2_sum", sum_m, 430);

      // Drop while pending, then ack with a coincident product
      res = 12'd50; res_rdy = 1'b1;
      tick();
      check("drop_pulse", drop_m, 1);
      check("drop_sum", sum_m, 430);
      res_rdy = 1'b0;
      tick();
      check("drop_once", drop_m, 0);
      check("drop_vld", vld_m, 1);
      check("drop_sum2", sum_m, 430);
      res = 12'd50; res_rdy = 1'b1; ack_m = 1'b1;
      tick();
      check("sim_vld", vld_m, 0);
      check("sim_sum", sum_m, 50);
      check("sim_cnt", cnt_m, 1);
      check("sim_drop", drop_m, 0);
      res_rdy = 1'b0; ack_m = 1'b0;
      tick();

      // Held level: high at reset release gives no capture
      res = 12'd100; res_rdy = 1'b1;
      #2 rstn_m = 1'b0;
      #1 check("lvl_rst_cnt", cnt_m, 0);
      rstn_m = 1'b1;
      tick(); tick(); tick();
      check("lvl_nocap", cnt_m, 0);
      for (int i = 0; i < 4; i++) begin
         res_rdy = 1'b0;
         tick();
         res_rdy = 1'b1;
         repeat (6) tick();
         if (i == 0) check("lvl_once", cnt_m, 1);
      end
      res_rdy = 1'b0;
      tick();
      check("lvl_cnt", cnt_m, 4);
      check("lvl_sum", sum_m, 400);
      check("lvl_vld", vld_m, 1);
      ack_m = 1'b1;
      tick();
      ack_m = 1'b0;

      // Asynchronous reset mid-frame
      deliver(12'd125);
      deliver(12'd160);
      check("mid_sum", sum_m, 285);
      #2 rstn_m = 1'b0;
      #1;
      check("mid_async_sum", sum_m, 0);
      check("mid_async_cnt", cnt_m, 0);
      #1 rstn_m = 1'b1;
      tick();
      deliver(12'd125);
      deliver(12'd160);
      deliver(12'd40);
      deliver(12'd105);
      check("mid_new_sum", sum_m, 430);
      check("mid_new_vld", vld_m, 1);

      // Saturation on the 12-bit instance
      rstn_s = 1'b1;
      tick();
      deliver(12'd1935);
      check("sat_sum1", sum_s, 1935);
      deliver(12'd1935);
      check("sat_sum2", sum_s, 3870);
      check("sat_flag2", sat_s, 0);
      deliver(12'd1935);
      check("sat_sum3", sum_s, 4095);
      check("sat_flag3", sat_s, 1);
      check("sat_vld3", vld_s, 0);
      deliver(12'd10);
      check("sat_sum4", sum_s, 4095);
      check("sat_flag4", sat_s, 1);
      check("sat_vld4", vld_s, 1);
      ack_s = 1'b1;
      tick();
      ack_s = 1'b0;
      check("sat_clr", sat_s, 0);
      check("sat_clr_sum", sum_s, 0);
      check("sat_clr_vld", vld_s, 0);

      // K=1 frames
      rstn_k = 1'b1;
      tick();
      deliver(12'd5);
      check("k1_vld", vld_k, 1);
      check("k1_sum", sum_k, 5);
      check("k1_cnt", cnt_k, 1);
      res = 12'd7; res_rdy = 1'b1; ack_k = 1'b1;
      tick();
      check("k1_vld7", vld_k, 1);
      check("k1_sum7", sum_k, 7);
      check("k1_drop7", drop_k, 0);
      res_rdy = 1'b0; ack_k = 1'b0;
      tick();
      check("k1_vld7b", vld_k, 1);
      check("k1_sum7b", sum_k, 7);
      res = 12'd9; res_rdy = 1'b1; ack_k = 1'b1;
      tick();
      check("k1_vld9", vld_k, 1);
      check("k1_sum9", sum_k, 9);
      res_rdy = 1'b0; ack_k = 1'b0;
      tick();
      check("k1_vld9b", vld_k, 1);
      check("k1_cnt9", cnt_k, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
